mul_writeback_arbiter: RTL

Merges the multiplier pipeline's final-stage output (the M5 register outputs) with the single-cycle ALU/memory writeback path onto the one ROB result-write port. The ALU path normally wins. Multiplier results that lose arbitration are parked in a small in-order FIFO, and back-pressure to the M4/M5 register is generated through `mul_stall`. A starvation guard periodically stalls the ALU path so that parked multiplier results always drain. The ROB write port is fully registered.

---
 rtl/mul_writeback_arbiter_if.sv | 44 ++++
 rtl/mul_writeback_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_writeback_arbiter_if.sv
// Writeback-side bundle: multiplier M5 output, ALU/memory writeback, the
// back-pressure strobes and the registered ROB result-write port.
interface mul_writeback_arbiter_if #(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WITDH = 3
);
  logic                       mul_valid;
  logic [INSTR_TYPE_SZ-1:0]   mul_instr_type;
  logic [WORD_SIZE-1:0]       mul_pc;
  logic [WORD_SIZE-1:0]       mul_result;
  logic [ROB_ENTRY_WITDH-1:0] mul_rob_id;
  logic                       mul_stall;

  logic                       alu_valid;
  logic [INSTR_TYPE_SZ-1:0]   alu_instr_type;
  logic [WORD_SIZE-1:0]       alu_pc;
  logic [WORD_SIZE-1:0]       alu_result;
  logic [ROB_ENTRY_WITDH-1:0] alu_rob_id;
  logic                       alu_stall;

  logic                       rob_wr_valid;
  logic [INSTR_TYPE_SZ-1:0]   rob_wr_instr_type;
  logic [WORD_SIZE-1:0]       rob_wr_pc;
  logic [WORD_SIZE-1:0]       rob_wr_result;
  logic [ROB_ENTRY_WITDH-1:0] rob_wr_rob_id;
  logic                       rob_wr_src;

  modport master (
    output mul_valid, mul_instr_type, mul_pc, mul_result, mul_rob_id,
    output alu_valid, alu_instr_type, alu_pc, alu_result, alu_rob_id,
    input  mul_stall, alu_stall,
    input  rob_wr_valid, rob_wr_instr_type, rob_wr_pc, rob_wr_result,
    input  rob_wr_rob_id, rob_wr_src
  );

  modport slave (
    input  mul_valid, mul_instr_type, mul_pc, mul_result, mul_rob_id,
    input  alu_valid, alu_instr_type, alu_pc, alu_result, alu_rob_id,
    output mul_stall, alu_stall,
    output rob_wr_valid, rob_wr_instr_type, rob_wr_pc, rob_wr_result,
    output rob_wr_rob_id, rob_wr_src
  );
endinterface

// File: rtl/mul_writeback_arbiter.sv
// Arbitrates multiplier and ALU results onto the single registered ROB write
// port; losing multiplier results park in an in-order FIFO with a starvation guard.
module mul_writeback_arbiter #(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WITDH = 3,
  parameter int DEPTH           = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  mul_writeback_arbiter_if.slave wb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENT_W = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WITDH;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C  = STV_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_ALU  = 2'd1;
  localparam logic [1:0] G_POP  = 2'd2;
  localparam logic [1:0] G_BYP  = 2'd3;

  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic                       wr_valid_q, wr_valid_d;
  logic                       wr_src_q, wr_src_d;
  logic [INSTR_TYPE_SZ-1:0]   wr_type_q, wr_type_d;
  logic [WORD_SIZE-1:0]       wr_pc_q, wr_pc_d;
  logic [WORD_SIZE-1:0]       wr_result_q, wr_result_d;
  logic [ROB_ENTRY_WITDH-1:0] wr_id_q, wr_id_d;

  logic             full, force_pop, mul_accept, push, pop;
  logic [1:0]       grant;
  logic [ENT_W-1:0] mul_entry, head_entry;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Stalls come only from registered state, never from this cycle's inputs.
  assign full       = (count_q == DEPTH_C);
  assign force_pop  = (starve_q == LIMIT_C) && (count_q != '0);
  assign mul_accept = wb.mul_valid && !full;

  assign mul_entry  = {wb.mul_instr_type, wb.mul_pc, wb.mul_result, wb.mul_rob_id};
  assign head_entry = fifo_q[head_q];

  always_comb begin
    grant = G_NONE;
    if (!flush) begin
      if (force_pop)           grant = G_POP;
      else if (wb.alu_valid)   grant = G_ALU;
      else if (count_q != '0)  grant = G_POP;
      else if (mul_accept)     grant = G_BYP;
    end
  end

  assign pop  = (grant == G_POP);
  assign push = mul_accept && !flush && (grant != G_BYP);

  always_comb begin
    head_d   = pop  ? next_ptr(head_q) : head_q;
    tail_d   = push ? next_ptr(tail_q) : tail_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    starve_d = starve_q;
    if (pop || !full)
      starve_d = '0;
    else if (grant == G_ALU && starve_q != LIMIT_C)
      starve_d = starve_q + STV_W'(1);
  end

  always_comb begin
    wr_valid_d  = (grant != G_NONE);
    wr_src_d    = wr_src_q;
    wr_type_d   = wr_type_q;
    wr_pc_d     = wr_pc_q;
    wr_result_d = wr_result_q;
    wr_id_d     = wr_id_q;
    case (grant)
      G_ALU: begin
        wr_src_d    = 1'b0;
        wr_type_d   = wb.alu_instr_type;
        wr_pc_d     = wb.alu_pc;
        wr_result_d = wb.alu_result;
        wr_id_d     = wb.alu_rob_id;
      end
      G_POP: begin
        wr_src_d = 1'b1;
        {wr_type_d, wr_pc_d, wr_result_d, wr_id_d} = head_entry;
      end
      G_BYP: begin
        wr_src_d = 1'b1;
        {wr_type_d, wr_pc_d, wr_result_d, wr_id_d} = mul_entry;
      end
      default: ;
    endcase
  end

  // Park storage carries no reset; validity is tracked by count/head/tail.
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= mul_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_src_q    <= 1'b0;
      wr_type_q   <= '0;
      wr_pc_q     <= '0;
      wr_result_q <= '0;
      wr_id_q     <= '0;
    end else if (flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      wr_valid_q  <= wr_valid_d;
      wr_src_q    <= wr_src_d;
      wr_type_q   <= wr_type_d;
      wr_pc_q     <= wr_pc_d;
      wr_result_q <= wr_result_d;
      wr_id_q     <= wr_id_d;
    end
  end

  assign wb.mul_stall         = full;
  assign wb.alu_stall         = force_pop;
  assign wb.rob_wr_valid      = wr_valid_q;
  assign wb.rob_wr_src        = wr_src_q;
  assign wb.rob_wr_instr_type = wr_type_q;
  assign wb.rob_wr_pc         = wr_pc_q;
  assign wb.rob_wr_result     = wr_result_q;
  assign wb.rob_wr_rob_id     = wr_id_q;

endmodule
